// File: rtl/router_fifo_buf_if.sv
// Bus between the router sync stage / destination and one output FIFO.
// The master side drives write/read requests and the flush; the FIFO (slave) side
// returns the read byte and the full/empty status.
interface router_fifo_buf_if #(
  parameter int WIDTH = 8
);
  logic             soft_reset;
  logic             write_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic             read_enb;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;

  modport master (
    output soft_reset, write_enb, lfd_state, data_in, read_enb,
    input  data_out, full, empty
  );

  modport slave (
    input  soft_reset, write_enb, lfd_state, data_in, read_enb,
    output data_out, full, empty
  );
endinterface

// File: rtl/router_fifo_buf.sv
// Per-destination output FIFO of the 1x3 router.
// Each entry stores {header_marker, byte}. The read side uses the marker to load a
// packet-length counter from the header and blanks data_out to zero once the
// parity byte has been presented and no further read arrives.
module router_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int ADDR  = 4
) (
  input logic               clk,
  input logic               resetn,
  router_fifo_buf_if.slave  fifo_if
);

  localparam int CNT_W = 7;

  logic [ADDR:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic [WIDTH:0]     mem_q [DEPTH];

  logic               full_w;
  logic               empty_w;
  logic               flush_w;
  logic               wr_en_w;
  logic               rd_en_w;
  logic [WIDTH:0]     rd_entry_w;

  // Status is decoded from registered pointers only; the extra MSB separates full from empty.
  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (wr_ptr_q[ADDR] != rd_ptr_q[ADDR]) &&
                   (wr_ptr_q[ADDR-1:0] == rd_ptr_q[ADDR-1:0]);

  // Hard reset and the sync-stage timeout flush have identical effect; both beat any access.
  assign flush_w = !resetn || fifo_if.soft_reset;

  // Requests are gated by the pre-edge status, so a write at full or a read at empty is ignored.
  assign wr_en_w    = fifo_if.write_enb && !full_w;
  assign rd_en_w    = fifo_if.read_enb  && !empty_w;
  assign rd_entry_w = mem_q[rd_ptr_q[ADDR-1:0]];

  assign fifo_if.full     = full_w;
  assign fifo_if.empty    = empty_w;
  assign fifo_if.data_out = data_out_q;

  // Next-state for pointers, packet counter and the registered read byte.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pkt_cnt_d  = pkt_cnt_q;
    data_out_d = data_out_q;

    if (wr_en_w) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (rd_en_w) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_out_d = rd_entry_w[WIDTH-1:0];
      if (rd_entry_w[WIDTH]) begin
        // Header: reload with payload length plus the parity byte, discarding any leftover count.
        pkt_cnt_d = CNT_W'(rd_entry_w[WIDTH-1:2]) + CNT_W'(1);
      end else if (pkt_cnt_q != '0) begin
        pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
      end
    end else if (pkt_cnt_q == '0) begin
      // Packet finished (or none in flight): return the output to zero.
      data_out_d = '0;
    end
  end

  // Pointer, counter and output registers with flush priority.
  always_ff @(posedge clk) begin
    if (flush_w) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage array; cleared on flush so no stale header marker survives into the next packet.
  always_ff @(posedge clk) begin
    if (flush_w) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_w) begin
      mem_q[wr_ptr_q[ADDR-1:0]] <= {fifo_if.lfd_state, fifo_if.data_in};
    end
  end

endmodule

// File: tb/tb_router_fifo_buf.sv
// Self-checking bench for router_fifo_buf. A queue of {marker, byte} entries is the
// scoreboard: pushed when an accepted write is driven, popped when the DUT presents
// the corresponding read byte. A small counter model predicts output blanking.
module tb_router_fifo_buf;

  logic clk;
  logic resetn;

  router_fifo_buf_if #(.WIDTH(8)) bus ();

  router_fifo_buf #(.WIDTH(8), .DEPTH(16), .ADDR(4)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .fifo_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [8:0]  sb_q [$];
  logic [6:0]  m_cnt;
  logic [7:0]  m_dout;
  string       phase;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Drive one clock of stimulus, advance the model, then compare outputs after the edge.
  task automatic cycle(input bit rstn, input bit srst, input bit we, input bit lfd,
                       input logic [7:0] din, input bit re);
    bit         m_full;
    bit         m_empty;
    logic [8:0] e;
    @(negedge clk);
    resetn         = rstn;
    bus.soft_reset = srst;
    bus.write_enb  = we;
    bus.lfd_state  = lfd;
    bus.data_in    = din;
    bus.read_enb   = re;

    m_full  = (sb_q.size() == 16);
    m_empty = (sb_q.size() == 0);
    if (!rstn || srst) begin
      sb_q.delete();
      m_cnt  = '0;
      m_dout = '0;
    end else begin
      if (re && !m_empty) begin
        e      = sb_q.pop_front();
        m_dout = e[7:0];
        if (e[8]) m_cnt = 7'(e[7:2]) + 7'd1;
        else if (m_cnt != 0) m_cnt = m_cnt - 7'd1;
      end else if (m_cnt == 0) begin
        m_dout = '0;
      end
      if (we && !m_full) sb_q.push_back({lfd, din});
    end

    @(posedge clk);
    #1;
    chk({phase, ":dout"},  32'(bus.data_out), 32'(m_dout));
    chk({phase, ":full"},  32'(bus.full),     32'(sb_q.size() == 16));
    chk({phase, ":empty"}, 32'(bus.empty),    32'(sb_q.size() == 0));
    $display("[%s] we=%0d lfd=%0d din=%02h re=%0d srst=%0d -> dout=%02h full=%0d empty=%0d",
             phase, we, lfd, din, re, srst, bus.data_out, bus.full, bus.empty);
  endtask

  task automatic wr(input bit lfd, input logic [7:0] din);
    cycle(1'b1, 1'b0, 1'b1, lfd, din, 1'b0);
  endtask

  task automatic rd();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // Watchdog so the run always ends even if the flow above stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn         = 1'b0;
    bus.soft_reset = 1'b0;
    bus.write_enb  = 1'b0;
    bus.lfd_state  = 1'b0;
    bus.data_in    = 8'h00;
    bus.read_enb   = 1'b0;
    m_cnt          = '0;
    m_dout         = '0;

    // 1: reset held with a write request present
    phase = "reset";
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'hAB, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'hAB, 1'b0);
    idle();
    chk("t1_empty", 32'(bus.empty), 32'd1);
    rd();
    chk("t1_nothing_stored", 32'(bus.data_out), 32'h00);

    // 2: packet pass-through with blanking after parity
    phase = "packet";
    wr(1'b1, 8'h0D);
    wr(1'b0, 8'hA1);
    wr(1'b0, 8'hA2);
    wr(1'b0, 8'hA3);
    wr(1'b0, 8'h5F);
    for (int i = 0; i < 5; i++) rd();
    chk("t2_parity", 32'(bus.data_out), 32'h5F);
    idle();
    chk("t2_blank", 32'(bus.data_out), 32'h00);
    chk("t2_empty", 32'(bus.empty), 32'd1);

    // 3: fill, overflow drop, drain; repeated to wrap the pointers
    for (int rep = 0; rep < 3; rep++) begin
      phase = $sformatf("wrap%0d", rep);
      for (int i = 0; i < 16; i++) wr(1'b0, 8'(i));
      chk("t3_full", 32'(bus.full), 32'd1);
      wr(1'b0, 8'hFF);
      for (int i = 0; i < 16; i++) rd();
      chk("t3_last", 32'(bus.data_out), 32'h0F);
      chk("t3_empty", 32'(bus.empty), 32'd1);
      idle();
    end

    // 4: simultaneous read/write at full and at empty
    phase = "simul";
    for (int i = 0; i < 16; i++) wr(1'b0, 8'(i));
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'hEE, 1'b1);
    chk("t4_full_rd", 32'(bus.data_out), 32'h00);
    chk("t4_full_drop", 32'(bus.full), 32'd0);
    for (int i = 0; i < 15; i++) rd();
    chk("t4_drained", 32'(bus.empty), 32'd1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h33, 1'b1);
    chk("t4_empty_wr", 32'(bus.empty), 32'd0);
    rd();
    chk("t4_read33", 32'(bus.data_out), 32'h33);
    idle();

    // 5: soft reset mid-packet, then a clean packet
    phase = "softrst";
    wr(1'b1, 8'h14);
    wr(1'b0, 8'hB1);
    wr(1'b0, 8'hB2);
    wr(1'b0, 8'hB3);
    wr(1'b0, 8'hB4);
    wr(1'b0, 8'hB5);
    wr(1'b0, 8'hBB);
    rd();
    chk("t5_hdr", 32'(bus.data_out), 32'h14);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("t5_flush_empty", 32'(bus.empty), 32'd1);
    chk("t5_flush_dout", 32'(bus.data_out), 32'h00);
    wr(1'b1, 8'h09);
    wr(1'b0, 8'hC1);
    wr(1'b0, 8'hC2);
    wr(1'b0, 8'h77);
    for (int i = 0; i < 4; i++) rd();
    chk("t5_parity", 32'(bus.data_out), 32'h77);
    idle();
    chk("t5_blank", 32'(bus.data_out), 32'h00);

    // 6: short packet resynchronised by the next header
    phase = "resync";
    wr(1'b1, 8'h14);
    wr(1'b0, 8'hD1);
    wr(1'b0, 8'hD2);
    wr(1'b1, 8'h06);
    wr(1'b0, 8'hE1);
    wr(1'b0, 8'hE2);
    for (int i = 0; i < 6; i++) rd();
    chk("t6_last", 32'(bus.data_out), 32'hE2);
    idle();
    chk("t6_blank", 32'(bus.data_out), 32'h00);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/router_fifo_buf.md
Name: router_fifo_buf

Overview:
Per-destination output FIFO of the 1x3 router. It sits directly downstream of the router's write-enable/synchronizer stage: one instance per output port, written on that port's write-enable bit. It feeds full/empty back upstream. Each entry carries a header-marker bit, so the read side can track packet length and blank its output after the final (parity) byte.

Parameters:
WIDTH, 8, data byte width
DEPTH, 16, number of entries (power of 2)
ADDR, 4, log2(DEPTH); pointers are ADDR+1 bits wide

Ports:
clk  input  1  clock, all logic on rising edge
resetn  input  1  synchronous, active-low reset
soft_reset  input  1  synchronous, active-high flush (timeout from sync stage)
write_enb  input  1  write request for this port
lfd_state  input  1  high when data_in is a header byte (load-first-data)
data_in  input  WIDTH  byte to store
read_enb  input  1  read request from destination
data_out  output  WIDTH  registered read data
full  output  1  all DEPTH entries occupied
empty  output  1  no entries occupied

Behaviour:
- Storage: DEPTH x (WIDTH+1) array; entry = {lfd_state, data_in}. Bit WIDTH is the header marker.
- Pointers wr_ptr and rd_ptr are ADDR+1 bits and wrap naturally modulo 2*DEPTH. Array index = ptr[ADDR-1:0].
- empty = (wr_ptr == rd_ptr).
- full = (wr_ptr[ADDR] != rd_ptr[ADDR]) && (wr_ptr[ADDR-1:0] == rd_ptr[ADDR-1:0]).
- full and empty are decoded combinationally from the registered pointers. They are never both 1.
- Write: write_enb && !full -> store {lfd_state, data_in} at wr_ptr; wr_ptr+1. Write while full is silently dropped; no state change.
- Read: read_enb && !empty -> data_out <= mem[rd_ptr][WIDTH-1:0]; rd_ptr+1. Read latency is 1 cycle.
- Read while empty: no pointer move, and no counter change.
- Packet counter pkt_cnt is 7 bits, internal. Header format: [7:2] payload length L (0..63), [1:0] destination address.
- On a read of an entry whose marker bit is 1: pkt_cnt <= L + 1 (payload plus parity). This reload overrides any residual count; a malformed packet is resynchronised on its next header.
- On a read of an entry whose marker is 0: if pkt_cnt != 0, pkt_cnt - 1; if pkt_cnt == 0, pkt_cnt stays 0.
- No read in a cycle:
  - pkt_cnt != 0 -> data_out holds its value.
  - pkt_cnt == 0 -> data_out <= 0.
  - Net effect: the cycle after the parity byte is presented with no new read, data_out returns to 0.
- Simultaneous read and write:
  - Both occur when !full && !empty; occupancy is unchanged.
  - When full: only the read occurs (write is gated by the pre-edge full). full drops next cycle.
  - When empty: only the write occurs. empty drops next cycle; the new byte is readable from the following cycle.
- Reset (resetn == 0): wr_ptr = 0, rd_ptr = 0, pkt_cnt = 0, data_out = 0, all array entries = 0. Result: empty = 1, full = 0.
- soft_reset == 1 with resetn == 1: same effect as reset. Any read or write in that cycle is discarded.
- Priority: resetn > soft_reset > read/write.
- soft_reset mid-packet discards all stored bytes. The next packet must start with a header.
- No combinational path from data_in to data_out. Only full and empty are combinational, and only from internal registers.

Test Plan:
1. Reset: hold resetn = 0 for 2 cycles with write_enb = 1 -> empty = 1, full = 0, data_out = 0x00; nothing stored after release.
2. Packet pass-through:
   - Stimulus: write 0x0D with lfd_state = 1 (L = 3, addr 1), then 0xA1, 0xA2, 0xA3, parity 0x5F with lfd_state = 0.
   - Then assert read_enb for 5 cycles.
   - Required: data_out = 0x0D, A1, A2, A3, 5F, each 1 cycle after its read. Next idle cycle data_out = 0x00, empty = 1.
3. Full and wrap:
   - Write 0x00..0x0F -> full = 1 after the 16th write.
   - 17th write (0xFF) is dropped.
   - Read 16 -> data_out = 0x00..0x0F in order, then empty = 1.
   - Repeat 3 times to exercise pointer wrap.
4. Simultaneous read/write:
   - At full, write + read -> 0x00 read out, new byte dropped, full = 0 next cycle.
   - At empty, write 0x33 + read -> no read, empty = 0 next cycle; next read returns 0x33.
5. Soft reset mid-packet: 6 bytes stored, pkt_cnt nonzero; pulse soft_reset for 1 cycle with read_enb = 1 -> next cycle empty = 1, data_out = 0x00, read discarded. A following new packet is read correctly.
6. Header resync: header L = 5 read, but only 2 payload bytes precede the next header (L = 1) -> counter reloads to 2. Second packet's 2 bytes are read out, then data_out = 0x00 on the next idle cycle.
